// File: rtl/if_queue_fetch.sv
// Fetch stage: I-cache handshake, pre-decode, next-PC prediction and IQ.
// Define IF_BHT_EN to predict branches with a 2-bit BHT instead of BTFN.
module if_queue_fetch #(
  parameter int                ADDR_W    = 32,
  parameter int                IQ_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BHT_IDX_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  output logic              icache_req,
  output logic [ADDR_W-1:0] icache_pc,
  input  logic [31:0]       icache_ins,
  input  logic              icache_valid,
  input  logic              rob_full,
  input  logic              lsb_full,
  input  logic              rs_full,
  output logic              dec_valid,
  output logic [31:0]       dec_ins,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [31:0]       dec_imm,
  output logic [31:0]       dec_rd_val,
  output logic              dec_pred_taken,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_target,
  input  logic              br_upd_valid,
  input  logic [ADDR_W-1:0] br_upd_pc,
  input  logic              br_upd_taken
);
  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    FETCH, WAIT, HOLD, DISCARD
  } state_e;

  typedef struct packed {
    logic [31:0]       ins;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       imm;
    logic [31:0]       rd_val;
    logic              pred;
  } iq_ent_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  iq_ent_t           iq_q [IQ_DEPTH];
  iq_ent_t           iq_d [IQ_DEPTH];

  logic [6:0]  opc;
  logic        op_lui, op_auipc, op_jal, op_jalr;
  logic        op_br, op_load, op_store, op_opimm;
  logic        is_shift, br_taken, pred, push, space;
  logic [31:0] imm, rd_val, pc32, i_imm;
  logic [ADDR_W-1:0] nxt_pc;
  logic        unused_bht;

  assign opc      = icache_ins[6:0];
  assign op_lui   = opc == 7'b0110111;
  assign op_auipc = opc == 7'b0010111;
  assign op_jal   = opc == 7'b1101111;
  assign op_jalr  = opc == 7'b1100111;
  assign op_br    = opc == 7'b1100011;
  assign op_load  = opc == 7'b0000011;
  assign op_store = opc == 7'b0100011;
  assign op_opimm = opc == 7'b0010011;
  assign is_shift = icache_ins[13:12] == 2'b01;
  assign i_imm    = {{20{icache_ins[31]}}, icache_ins[31:20]};
  assign pc32     = 32'(pc_q);

  always_comb begin
    imm = '0;
    unique case (1'b1)
      op_lui, op_auipc:
        imm = {icache_ins[31:12], 12'b0};
      op_jal:
        imm = {{12{icache_ins[31]}}, icache_ins[19:12],
               icache_ins[20], icache_ins[30:21], 1'b0};
      op_jalr, op_load:
        imm = i_imm;
      op_opimm:
        imm = is_shift ? {27'b0, icache_ins[24:20]} : i_imm;
      op_store:
        imm = {{21{icache_ins[31]}}, icache_ins[30:25],
               icache_ins[11:7]};
      op_br:
        imm = {{20{icache_ins[31]}}, icache_ins[7],
               icache_ins[30:25], icache_ins[11:8], 1'b0};
      default:
        imm = '0;
    endcase
  end

  always_comb begin
    rd_val = '0;
    if (op_auipc)
      rd_val = pc32 + imm;
    else if (op_lui)
      rd_val = imm;
    else if (op_jal || op_jalr)
      rd_val = pc32 + 32'd4;
  end

`ifdef IF_BHT_EN
  localparam int BHT_N = 2 ** BHT_IDX_W;

  logic [1:0]           bht_q [BHT_N];
  logic [1:0]           bht_d [BHT_N];
  logic [BHT_IDX_W-1:0] upd_idx;

  assign upd_idx    = br_upd_pc[BHT_IDX_W+1:2];
  assign br_taken   = bht_q[pc_q[BHT_IDX_W+1:2]][1];
  assign unused_bht = ^br_upd_pc;

  always_comb begin
    bht_d = bht_q;
    if (rdy && br_upd_valid) begin
      if (br_upd_taken && bht_q[upd_idx] != 2'b11)
        bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
      else if (!br_upd_taken && bht_q[upd_idx] != 2'b00)
        bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++)
        bht_q[i] <= 2'b01;
    end else begin
      bht_q <= bht_d;
    end
  end
`else
  assign br_taken   = imm[31];
  assign unused_bht = ^{br_upd_valid, br_upd_taken, br_upd_pc};
`endif

  assign pred   = op_jal || (op_br && br_taken);
  assign nxt_pc = pred ? pc_q + ADDR_W'($signed(imm))
                       : pc_q + ADDR_W'(4);

  assign dec_valid = rdy && count_q != '0 && !flush &&
                     !rob_full && !lsb_full && !rs_full;
  // A same-cycle pop frees the slot the new request reserves.
  assign space     = (count_q - CW'(dec_valid)) < CW'(IQ_DEPTH);
  assign icache_pc = pc_q;

  assign dec_ins        = iq_q[head_q].ins;
  assign dec_pc         = iq_q[head_q].pc;
  assign dec_imm        = iq_q[head_q].imm;
  assign dec_rd_val     = iq_q[head_q].rd_val;
  assign dec_pred_taken = iq_q[head_q].pred;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    iq_d       = iq_q;
    icache_req = 1'b0;
    push       = 1'b0;
    if (rdy) begin
      unique case (state_q)
        FETCH: begin
          if (!flush && space && rst_n) begin
            icache_req = 1'b1;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (icache_valid) begin
            push    = 1'b1;
            state_d = op_jalr ? HOLD : FETCH;
            if (!op_jalr)
              pc_d = nxt_pc;
          end
        end
        DISCARD: begin
          if (icache_valid)
            state_d = FETCH;
        end
        default: ;
      endcase
      if (flush) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        pc_d    = flush_target;
        state_d = ((state_q == WAIT || state_q == DISCARD) &&
                   !icache_valid) ? DISCARD : FETCH;
      end else begin
        if (push) begin
          iq_d[tail_q] = '{ins: icache_ins, pc: pc_q, imm: imm,
                           rd_val: rd_val, pred: pred};
          tail_d = tail_q + PW'(1);
        end
        if (dec_valid)
          head_d = head_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(dec_valid);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < IQ_DEPTH; i++)
        iq_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      iq_q    <= iq_d;
    end
  end
endmodule

// File: tb/tb_if_queue_fetch.sv
// Directed bench for if_queue_fetch: vector table plus corner sequences.
module tb_if_queue_fetch;
  logic        clk = 1'b0;
  logic        rst_n, rdy;
  logic        icache_req, icache_valid;
  logic [31:0] icache_pc, icache_ins;
  logic        rob_full, lsb_full, rs_full;
  logic        dec_valid, dec_pred_taken;
  logic [31:0] dec_ins, dec_pc, dec_imm, dec_rd_val;
  logic        flush;
  logic [31:0] flush_target;
  logic        br_upd_valid, br_upd_taken;
  logic [31:0] br_upd_pc;

  always #5 clk = ~clk;

  if_queue_fetch #(
    .ADDR_W(32), .IQ_DEPTH(8), .RESET_PC(32'h0), .BHT_IDX_W(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .icache_req(icache_req), .icache_pc(icache_pc),
    .icache_ins(icache_ins), .icache_valid(icache_valid),
    .rob_full(rob_full), .lsb_full(lsb_full), .rs_full(rs_full),
    .dec_valid(dec_valid), .dec_ins(dec_ins), .dec_pc(dec_pc),
    .dec_imm(dec_imm), .dec_rd_val(dec_rd_val),
    .dec_pred_taken(dec_pred_taken),
    .flush(flush), .flush_target(flush_target),
    .br_upd_valid(br_upd_valid), .br_upd_pc(br_upd_pc),
    .br_upd_taken(br_upd_taken)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rdv;
    logic        pred;
  } vec_t;

  localparam logic [31:0] ADDI5 = 32'h0050_0093;

  vec_t tbl [12];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic        fwd_pred;
  logic [31:0] fwd_next;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input int i, input logic [31:0] ins,
                      input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] rdv, input logic pred);
    tbl[i].ins  = ins;
    tbl[i].pc   = pc;
    tbl[i].imm  = imm;
    tbl[i].rdv  = rdv;
    tbl[i].pred = pred;
  endtask

  initial begin
    setv(0,  ADDI5,         32'h00, 32'h5,        32'h0,        1'b0);
    setv(1,  ADDI5,         32'h04, 32'h5,        32'h0,        1'b0);
    setv(2,  32'h1234_5137, 32'h08, 32'h1234_5000, 32'h1234_5000, 1'b0);
    setv(3,  32'h0000_1197, 32'h0C, 32'h1000,     32'h100C,     1'b0);
    setv(4,  32'h0200_00EF, 32'h10, 32'h20,       32'h14,       1'b1);
    setv(5,  32'h4030_D093, 32'h30, 32'h3,        32'h0,        1'b0);
    setv(6,  32'hFE20_AE23, 32'h34, 32'hFFFF_FFFC, 32'h0,       1'b0);
    setv(7,  32'hFFF0_2283, 32'h38, 32'hFFFF_FFFF, 32'h0,       1'b0);
    setv(8,  32'h0000_0013, 32'h3C, 32'h0,        32'h0,        1'b0);
    setv(9,  32'hFE00_0CE3, 32'h40, 32'hFFFF_FFF8, 32'h0,       1'b1);
    setv(10, 32'h0000_0463, 32'h38, 32'h8,        32'h0,        1'b0);
    setv(11, 32'h0000_8067, 32'h3C, 32'h0,        32'h40,       1'b0);
`ifdef IF_BHT_EN
    fwd_pred = 1'b1;
    fwd_next = 32'h48;
`else
    fwd_pred = 1'b0;
    fwd_next = 32'h44;
`endif

    rst_n = 1'b1; rdy = 1'b1;
    icache_valid = 1'b0; icache_ins = '0;
    rob_full = 1'b0; lsb_full = 1'b0; rs_full = 1'b0;
    flush = 1'b0; flush_target = '0;
    br_upd_valid = 1'b0; br_upd_pc = '0; br_upd_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", icache_req, 1'b0);
    chk("rst_dec_valid", dec_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; rdy = 1'b0;
    #1;
    chk("rdy_lo_req", icache_req, 1'b0);
    tick; tick;
    chk("rdy_lo_frozen", icache_req, 1'b0);
    rdy = 1'b1;
    #1;
    chk("rdy_hi_req", icache_req, 1'b1);
    chk("rdy_hi_pc", icache_pc, 32'h0);

    // Three taken updates at 0x40 while flush holds fetch at 0.
    flush = 1'b1; flush_target = 32'h0;
    br_upd_valid = 1'b1; br_upd_pc = 32'h40; br_upd_taken = 1'b1;
    tick; tick; tick;
    flush = 1'b0; br_upd_valid = 1'b0;
    #1;

    for (int i = 0; i < 12; i++) begin
      chk($sformatf("v%0d_req", i), icache_req, 1'b1);
      chk($sformatf("v%0d_req_pc", i), icache_pc, tbl[i].pc);
      tick;
      icache_valid = 1'b1; icache_ins = tbl[i].ins;
      tick;
      icache_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_dvalid", i), dec_valid, 1'b1);
      chk($sformatf("v%0d_dpc", i), dec_pc, tbl[i].pc);
      chk($sformatf("v%0d_dins", i), dec_ins, tbl[i].ins);
      chk($sformatf("v%0d_imm", i), dec_imm, tbl[i].imm);
      chk($sformatf("v%0d_rdval", i), dec_rd_val, tbl[i].rdv);
      chk($sformatf("v%0d_pred", i), dec_pred_taken, tbl[i].pred);
    end

    chk("jalr_no_req", icache_req, 1'b0);
    tick;
    chk("hold_no_req", icache_req, 1'b0);
    chk("hold_empty", dec_valid, 1'b0);
    tick;
    chk("hold_no_req2", icache_req, 1'b0);
    flush = 1'b1; flush_target = 32'h100;
    tick;
    flush = 1'b0;
    #1;
    chk("hold_flush_req", icache_req, 1'b1);
    chk("hold_flush_pc", icache_pc, 32'h100);
    chk("hold_flush_empty", dec_valid, 1'b0);

    tick;
    flush = 1'b1; flush_target = 32'h200;
    #1;
    chk("wait_flush_noreq", icache_req, 1'b0);
    tick;
    flush = 1'b0; icache_valid = 1'b1; icache_ins = ADDI5;
    #1;
    chk("discard_noreq", icache_req, 1'b0);
    tick;
    icache_valid = 1'b0;
    #1;
    chk("discard_req", icache_req, 1'b1);
    chk("discard_pc", icache_pc, 32'h200);
    chk("discard_dropped", dec_valid, 1'b0);

    tick;
    flush = 1'b1; flush_target = 32'h300; icache_valid = 1'b1;
    tick;
    flush = 1'b0; icache_valid = 1'b0;
    #1;
    chk("flushvld_req", icache_req, 1'b1);
    chk("flushvld_pc", icache_pc, 32'h300);
    chk("flushvld_dropped", dec_valid, 1'b0);

    flush = 1'b1; flush_target = 32'h40;
    tick;
    flush = 1'b0;
    #1;
    chk("fwd_req_pc", icache_pc, 32'h40);
    tick;
    icache_valid = 1'b1; icache_ins = 32'h0000_0463;
    tick;
    icache_valid = 1'b0;
    #1;
    chk("fwd_dvalid", dec_valid, 1'b1);
    chk("fwd_imm", dec_imm, 32'h8);
    chk("fwd_pred", dec_pred_taken, fwd_pred);
    chk("fwd_req", icache_req, 1'b1);
    chk("fwd_next_pc", icache_pc, fwd_next);
    flush = 1'b1; flush_target = 32'h300;
    tick;
    flush = 1'b0;
    #1;
    chk("bp_start_pc", icache_pc, 32'h300);
    chk("bp_start_empty", dec_valid, 1'b0);

    rob_full = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp%0d_req", i), icache_req, 1'b1);
      chk($sformatf("bp%0d_pc", i), icache_pc, 32'h300 + 32'(4 * i));
      tick;
      icache_valid = 1'b1; icache_ins = ADDI5;
      tick;
      icache_valid = 1'b0;
      #1;
    end
    chk("full_no_req", icache_req, 1'b0);
    chk("full_no_dec", dec_valid, 1'b0);
    rob_full = 1'b0; lsb_full = 1'b1;
    tick;
    chk("lsb_full_no_dec", dec_valid, 1'b0);
    chk("lsb_full_no_req", icache_req, 1'b0);
    lsb_full = 1'b0; rs_full = 1'b1;
    tick;
    chk("rs_full_no_dec", dec_valid, 1'b0);
    rs_full = 1'b0;
    #1;
    chk("rel_dvalid", dec_valid, 1'b1);
    chk("rel_dpc0", dec_pc, 32'h300);
    chk("rel_req", icache_req, 1'b1);
    chk("rel_req_pc", icache_pc, 32'h320);
    for (int k = 1; k < 8; k++) begin
      tick;
      chk($sformatf("pop%0d_valid", k), dec_valid, 1'b1);
      chk($sformatf("pop%0d_pc", k), dec_pc, 32'h300 + 32'(4 * k));
    end
    tick;
    chk("drained", dec_valid, 1'b0);

    rst_n = 1'b0;
    #1;
    chk("midrst_req", icache_req, 1'b0);
    chk("midrst_dec", dec_valid, 1'b0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("postrst_req", icache_req, 1'b1);
    chk("postrst_pc", icache_pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
